// File: rtl/touch_display_ctrl.sv
// touch_display_ctrl
//   Averages batches of 2**AVG_LOG2 touch samples and holds the result on
//   X_COORD/Y_COORD for the hex decoder. Blanks the display after
//   TIMEOUT_CYCLES clocks without a touch sample.
//   Optional feature macro: TOUCH_DISP_FREEZE_EN adds a FREEZE input that
//   holds the displayed value and suspends the blanking timeout.
module touch_display_ctrl #(
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VALID,
  input  logic [11:0] X_IN,
  input  logic [11:0] Y_IN,
`ifdef TOUCH_DISP_FREEZE_EN
  input  logic        FREEZE,
`endif
  output logic [11:0] X_COORD,
  output logic [11:0] Y_COORD,
  output logic        BLANK,
  output logic        UPDATE
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW_PEND = 2'd1,
    SHOW      = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ACC_W-1:0] acc_x_reg, acc_x_next;
  logic [ACC_W-1:0] acc_y_reg, acc_y_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic [11:0]      x_coord_reg, x_coord_next;
  logic [11:0]      y_coord_reg, y_coord_next;
  logic             blank_reg, blank_next;
  logic             update_reg, update_next;

  logic             freeze;
  logic [ACC_W-1:0] sum_x, sum_y;
  logic             batch_done;
  logic             commit;
  logic             expire;

`ifdef TOUCH_DISP_FREEZE_EN
  assign freeze = FREEZE;
`else
  assign freeze = 1'b0;
`endif

  // Running sums including the sample currently presented.
  assign sum_x = acc_x_reg + ACC_W'(X_IN);
  assign sum_y = acc_y_reg + ACC_W'(Y_IN);

  // A batch closes on the edge that samples its last VALID; freeze discards it.
  assign batch_done = VALID && (cnt_reg == LAST_IDX);
  assign commit     = batch_done && !freeze;

  // Timeout only fires without a coincident VALID; a fresh sample always wins.
  assign expire = !VALID && !freeze && (state_reg != IDLE) && (tmo_reg == TMO_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: batch commit shows the display, timeout returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (VALID) state_next = commit ? SHOW : SHOW_PEND;
      end
      SHOW_PEND: begin
        if (commit)      state_next = SHOW;
        else if (expire) state_next = IDLE;
      end
      SHOW: begin
        if (expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values: accumulation, averaging, timeout counting.
  always_comb begin
    acc_x_next   = acc_x_reg;
    acc_y_next   = acc_y_reg;
    cnt_next     = cnt_reg;
    tmo_next     = tmo_reg;
    x_coord_next = x_coord_reg;
    y_coord_next = y_coord_reg;
    blank_next   = blank_reg;
    update_next  = 1'b0;

    if (VALID) begin
      tmo_next = '0;
      if (batch_done) begin
        acc_x_next = '0;
        acc_y_next = '0;
        cnt_next   = '0;
        if (!freeze) begin
          x_coord_next = sum_x[ACC_W-1:AVG_LOG2];
          y_coord_next = sum_y[ACC_W-1:AVG_LOG2];
          blank_next   = 1'b0;
          update_next  = 1'b1;
        end
      end else begin
        acc_x_next = sum_x;
        acc_y_next = sum_y;
        cnt_next   = cnt_reg + CNT_W'(1);
      end
    end else if (state_reg == IDLE) begin
      tmo_next = '0;
    end else if (expire) begin
      tmo_next     = '0;
      acc_x_next   = '0;
      acc_y_next   = '0;
      cnt_next     = '0;
      x_coord_next = '0;
      y_coord_next = '0;
      blank_next   = 1'b1;
    end else if (!freeze) begin
      tmo_next = tmo_reg + TMO_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_x_reg   <= '0;
      acc_y_reg   <= '0;
      cnt_reg     <= '0;
      tmo_reg     <= '0;
      x_coord_reg <= '0;
      y_coord_reg <= '0;
      blank_reg   <= 1'b1;
      update_reg  <= 1'b0;
    end else begin
      acc_x_reg   <= acc_x_next;
      acc_y_reg   <= acc_y_next;
      cnt_reg     <= cnt_next;
      tmo_reg     <= tmo_next;
      x_coord_reg <= x_coord_next;
      y_coord_reg <= y_coord_next;
      blank_reg   <= blank_next;
      update_reg  <= update_next;
    end
  end

  assign X_COORD = x_coord_reg;
  assign Y_COORD = y_coord_reg;
  assign BLANK   = blank_reg;
  assign UPDATE  = update_reg;

endmodule

// File: tb/tb_touch_display_ctrl.sv
// Testbench for touch_display_ctrl (AVG_LOG2=2, TIMEOUT_CYCLES=16).
// Directed scenarios followed by random traffic, all checked against a
// sample-queue reference model.
module tb_touch_display_ctrl;

  localparam int AVG_LOG2 = 2;
  localparam int BATCH    = 1 << AVG_LOG2;
  localparam int TIMEOUT  = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VALID;
  logic [11:0] X_IN;
  logic [11:0] Y_IN;
  logic [11:0] X_COORD;
  logic [11:0] Y_COORD;
  logic        BLANK;
  logic        UPDATE;

  touch_display_ctrl #(
    .AVG_LOG2      (AVG_LOG2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .VALID  (VALID),
    .X_IN   (X_IN),
    .Y_IN   (Y_IN),
    .X_COORD(X_COORD),
    .Y_COORD(Y_COORD),
    .BLANK  (BLANK),
    .UPDATE (UPDATE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: pending samples, idle count, displayed values.
  int q_x[$];
  int q_y[$];
  int idle_cnt;
  bit active;
  int exp_x, exp_y;
  bit exp_blank, exp_update;
  int step_no = 0;

  function automatic void model_reset();
    q_x.delete();
    q_y.delete();
    idle_cnt   = 0;
    active     = 0;
    exp_x      = 0;
    exp_y      = 0;
    exp_blank  = 1;
    exp_update = 0;
  endfunction

  function automatic void model_step(bit v, int x, int y);
    int sx, sy;
    exp_update = 0;
    if (v) begin
      q_x.push_back(x);
      q_y.push_back(y);
      idle_cnt = 0;
      active   = 1;
      if (q_x.size() == BATCH) begin
        sx = 0;
        sy = 0;
        foreach (q_x[i]) begin
          sx += q_x[i];
          sy += q_y[i];
        end
        exp_x      = sx / BATCH;
        exp_y      = sy / BATCH;
        exp_blank  = 0;
        exp_update = 1;
        q_x.delete();
        q_y.delete();
      end
    end else if (active) begin
      idle_cnt++;
      if (idle_cnt == TIMEOUT) begin
        active    = 0;
        idle_cnt  = 0;
        exp_blank = 1;
        exp_x     = 0;
        exp_y     = 0;
        q_x.delete();
        q_y.delete();
      end
    end
  endfunction

  task automatic check_all(string tag);
    total++;
    assert (X_COORD === 12'(exp_x)) else begin
      bad++;
      $error("FAIL %s x_coord step=%0d got=%h exp=%h", tag, step_no, X_COORD, 12'(exp_x));
    end
    total++;
    assert (Y_COORD === 12'(exp_y)) else begin
      bad++;
      $error("FAIL %s y_coord step=%0d got=%h exp=%h", tag, step_no, Y_COORD, 12'(exp_y));
    end
    total++;
    assert (BLANK === exp_blank) else begin
      bad++;
      $error("FAIL %s blank step=%0d got=%b exp=%b", tag, step_no, BLANK, exp_blank);
    end
    total++;
    assert (UPDATE === exp_update) else begin
      bad++;
      $error("FAIL %s update step=%0d got=%b exp=%b", tag, step_no, UPDATE, exp_update);
    end
  endtask

  // One clock: present inputs, advance model at the edge, check 1ns later.
  task automatic tick(bit v, int x, int y, string tag);
    VALID = v;
    X_IN  = 12'(x);
    Y_IN  = 12'(y);
    @(posedge CLK);
    model_step(v, x, y);
    step_no++;
    #1;
    check_all(tag);
    $display("step %0d %s v=%0b x_in=%h y_in=%h -> x=%h y=%h blank=%b upd=%b",
             step_no, tag, v, X_IN, Y_IN, X_COORD, Y_COORD, BLANK, UPDATE);
  endtask

  task automatic do_reset(int n, string tag);
    RST   = 1'b1;
    VALID = 1'b0;
    repeat (n) @(posedge CLK);
    model_reset();
    step_no++;
    #1;
    check_all(tag);
    $display("step %0d %s reset -> x=%h y=%h blank=%b upd=%b",
             step_no, tag, X_COORD, Y_COORD, BLANK, UPDATE);
    RST = 1'b0;
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) tick(0, 0, 0, tag);
  endtask

  initial begin
    RST   = 1'b1;
    VALID = 1'b0;
    X_IN  = '0;
    Y_IN  = '0;
    model_reset();
    #2;

    // 1: reset, then long idle with no change
    do_reset(2, "reset");
    idle(100, "idle100");

    // 2: one batch, average 0x106 / 0x200
    tick(1, 12'h100, 12'h200, "batch1");
    tick(1, 12'h104, 12'h200, "batch1");
    tick(1, 12'h108, 12'h200, "batch1");
    tick(1, 12'h10C, 12'h200, "batch1");
    total++;
    assert (X_COORD === 12'h106 && UPDATE === 1'b1) else begin
      bad++;
      $error("FAIL batch1_direct got x=%h upd=%b exp x=106 upd=1", X_COORD, UPDATE);
    end

    // 3: timeout blanks on the 16th idle edge
    idle(TIMEOUT - 1, "pre_timeout");
    total++;
    assert (BLANK === 1'b0) else begin
      bad++;
      $error("FAIL early_blank got=%b exp=0", BLANK);
    end
    idle(1, "timeout");
    total++;
    assert (BLANK === 1'b1 && X_COORD === 12'h000) else begin
      bad++;
      $error("FAIL timeout_blank got blank=%b x=%h exp blank=1 x=000", BLANK, X_COORD);
    end
    idle(3, "post_timeout");

    // 4: partial batch discarded by timeout
    for (int i = 0; i < 3; i++) tick(1, 12'hFFF, 12'hFFF, "partial");
    idle(TIMEOUT, "partial_to");
    for (int i = 0; i < 4; i++) tick(1, 12'h010, 12'h010, "after_partial");
    total++;
    assert (X_COORD === 12'h010) else begin
      bad++;
      $error("FAIL partial_discard got=%h exp=010", X_COORD);
    end

    // 5: full-scale batch, then VALID on the exact expiry cycle
    for (int i = 0; i < 4; i++) tick(1, 12'hFFF, 12'hFFF, "fullscale");
    idle(TIMEOUT - 1, "near_expiry");
    tick(1, 12'hFFF, 12'hFFF, "expiry_valid");
    idle(TIMEOUT - 1, "restart");
    for (int i = 0; i < 3; i++) tick(1, 12'hFFF, 12'hFFF, "fullscale2");
    total++;
    assert (X_COORD === 12'hFFF && BLANK === 1'b0) else begin
      bad++;
      $error("FAIL no_overflow got x=%h blank=%b exp x=FFF blank=0", X_COORD, BLANK);
    end

    // 6: reset mid-batch discards the samples
    tick(1, 12'h123, 12'h321, "midbatch");
    tick(1, 12'h456, 12'h654, "midbatch");
    do_reset(1, "mid_reset");
    tick(1, 12'h020, 12'h040, "after_reset");
    tick(1, 12'h022, 12'h042, "after_reset");
    tick(1, 12'h024, 12'h044, "after_reset");
    tick(1, 12'h026, 12'h046, "after_reset");

    // Random traffic with idle gaps and occasional resets
    for (int n = 0; n < 500; n++) begin
      if ((n % 90) == 45) idle(TIMEOUT + $urandom_range(0, 4) - 2, "rnd_gap");
      else if ($urandom_range(0, 149) == 0) do_reset(1, "rnd_reset");
      else tick(($urandom_range(0, 9) < 4), $urandom_range(0, 4095),
                $urandom_range(0, 4095), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
